// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the stall controller and the 5-stage datapath.
// The controller side (master) drives the enables, flushes, the data memory
// request and the timeout flag. The datapath side (slave) supplies the
// hazard and memory status bits.
interface pipe_stall_ctrl_if;
  // Datapath -> controller
  logic       idex_mem_rd;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       branch_taken;
  logic       exmem_valid;
  logic       exmem_mem_rd;
  logic       exmem_mem_wr;
  logic       dmem_ready;

  // Controller -> datapath
  logic       dmem_req;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       memwb_flush;
  logic       mem_timeout;

  modport master (
    input  idex_mem_rd, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           exmem_valid, exmem_mem_rd, exmem_mem_wr, dmem_ready,
    output dmem_req, pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_flush, mem_timeout
  );

  modport slave (
    output idex_mem_rd, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           exmem_valid, exmem_mem_rd, exmem_mem_wr, dmem_ready,
    input  dmem_req, pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_flush, mem_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer for the 5-stage RISC-V core.
// Produces PC / pipeline-register enables and flushes from load-use hazards,
// taken branches and a multi-cycle data memory handshake with timeout.
// Controls are combinational from state and inputs; state, wait counter and
// the sticky timeout flag are registered. Reset is synchronous, active-high.
// Optional stall performance counters are built when PIPE_STALL_CNT_EN is
// defined.
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stall_ctrl_if.master    bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_mem_cnt,
  output logic [CNT_W-1:0]     stall_lu_cnt
`endif
);

  // A zero timeout disables the check but still needs a 1-bit counter.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_acc;
  logic lu_haz;

  // Controls for a cycle in which memory is not holding the pipeline.
  logic flow_pc_en, flow_ifid_en, flow_ifid_flush, flow_idex_flush, flow_lu;

  // Combinational control outputs.
  logic dmem_req_c, pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
  logic ifid_flush_c, idex_flush_c, memwb_flush_c;
  logic lu_bubble_c;

  // Hazard and memory-access decode from the pipeline control bits.
  always_comb begin
    mem_acc = bus.exmem_valid & (bus.exmem_mem_rd | bus.exmem_mem_wr);
    lu_haz  = bus.idex_mem_rd & (bus.idex_rd != 5'd0) &
              ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));
  end

  // Branch squash beats the load-use bubble: both younger instructions die anyway.
  always_comb begin
    flow_pc_en      = 1'b1;
    flow_ifid_en    = 1'b1;
    flow_ifid_flush = 1'b0;
    flow_idex_flush = 1'b0;
    flow_lu         = 1'b0;
    if (bus.branch_taken) begin
      flow_ifid_flush = 1'b1;
      flow_idex_flush = 1'b1;
    end else if (lu_haz) begin
      flow_pc_en      = 1'b0;
      flow_ifid_en    = 1'b0;
      flow_idex_flush = 1'b1;
      flow_lu         = 1'b1;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dmem_req_c    = 1'b0;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    memwb_flush_c = 1'b0;
    lu_bubble_c   = 1'b0;

    if (rst) begin
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      memwb_flush_c = 1'b1;
      state_d       = RUN;
      wait_cnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          dmem_req_c = mem_acc;
          if (mem_acc && !bus.dmem_ready) begin
            memwb_flush_c = 1'b1;
            state_d       = MEM_WAIT;
            wait_cnt_d    = WAIT_W'(1);
          end else begin
            pc_en_c      = flow_pc_en;
            ifid_en_c    = flow_ifid_en;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            ifid_flush_c = flow_ifid_flush;
            idex_flush_c = flow_idex_flush;
            lu_bubble_c  = flow_lu;
          end
        end
        MEM_WAIT: begin
          dmem_req_c = 1'b1;
          if (bus.dmem_ready) begin
            pc_en_c      = flow_pc_en;
            ifid_en_c    = flow_ifid_en;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            ifid_flush_c = flow_ifid_flush;
            idex_flush_c = flow_idex_flush;
            lu_bubble_c  = flow_lu;
            state_d      = RUN;
            wait_cnt_d   = '0;
          end else begin
            memwb_flush_c = 1'b1;
            wait_cnt_d    = wait_cnt_q + WAIT_W'(1);
            if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) begin
              state_d = ERR;
            end
          end
        end
        ERR: begin
          memwb_flush_c = 1'b1;
        end
        default: begin
          memwb_flush_c = 1'b1;
          state_d       = RUN;
          wait_cnt_d    = '0;
        end
      endcase
    end
  end

  // Sticky error flag: set on entry to ERR, cleared only by reset.
  always_comb begin
    mem_timeout_d = rst ? 1'b0 : (mem_timeout_q | (state_d == ERR));
  end

  // State, wait counter and error flag registers (reset folded into _d).
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  // Drive the datapath-facing controls.
  always_comb begin
    bus.dmem_req    = dmem_req_c;
    bus.pc_en       = pc_en_c;
    bus.ifid_en     = ifid_en_c;
    bus.idex_en     = idex_en_c;
    bus.exmem_en    = exmem_en_c;
    bus.ifid_flush  = ifid_flush_c;
    bus.idex_flush  = idex_flush_c;
    bus.memwb_flush = memwb_flush_c;
    bus.mem_timeout = mem_timeout_q & ~rst;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_mem_cnt_q, stall_mem_cnt_d;
  logic [CNT_W-1:0] stall_lu_cnt_q, stall_lu_cnt_d;

  // Saturating stall counters: frozen-EX/MEM cycles and load-use bubbles.
  always_comb begin
    stall_mem_cnt_d = stall_mem_cnt_q;
    stall_lu_cnt_d  = stall_lu_cnt_q;
    if (rst) begin
      stall_mem_cnt_d = '0;
      stall_lu_cnt_d  = '0;
    end else begin
      if (!exmem_en_c && (stall_mem_cnt_q != {CNT_W{1'b1}})) begin
        stall_mem_cnt_d = stall_mem_cnt_q + CNT_W'(1);
      end
      if (lu_bubble_c && (stall_lu_cnt_q != {CNT_W{1'b1}})) begin
        stall_lu_cnt_d = stall_lu_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_mem_cnt_q <= stall_mem_cnt_d;
    stall_lu_cnt_q  <= stall_lu_cnt_d;
  end

  assign stall_mem_cnt = stall_mem_cnt_q;
  assign stall_lu_cnt  = stall_lu_cnt_q;
`else
  // CNT_W only shapes the optional counters.
  if (CNT_W == 0) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. Each step drives inputs, queues the
// expected control vector, and checks it on the following falling edge.
module tb_pipe_stall_ctrl;

  localparam int unsigned TO = 4;

  // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, mem_timeout}
  localparam logic [8:0] RST_V    = 9'b0_0000_111_0;
  localparam logic [8:0] NORM     = 9'b0_1111_000_0;
  localparam logic [8:0] NORM_REQ = 9'b1_1111_000_0;
  localparam logic [8:0] LU       = 9'b0_0011_010_0;
  localparam logic [8:0] LU_REQ   = 9'b1_0011_010_0;
  localparam logic [8:0] BR       = 9'b0_1111_110_0;
  localparam logic [8:0] BR_REQ   = 9'b1_1111_110_0;
  localparam logic [8:0] STALL    = 9'b1_0000_001_0;
  localparam logic [8:0] ERRV     = 9'b0_0000_001_1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus();

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_mem_cnt;
  logic [31:0] stall_lu_cnt;
`endif

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_mem_cnt (stall_mem_cnt),
    .stall_lu_cnt  (stall_lu_cnt)
`endif
  );

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [8:0] observed();
    return {bus.dmem_req, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
            bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.mem_timeout};
  endfunction

  task automatic check_out();
    logic [8:0] got;
    logic [8:0] e;
    string      t;
    got = observed();
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", t, got, e);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ldr,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic v,
                      input logic mrd, input logic mwr, input logic rdy,
                      input logic [8:0] e);
    rst              = r;
    bus.idex_mem_rd  = ldr;
    bus.idex_rd      = rd;
    bus.ifid_rs1     = rs1;
    bus.ifid_rs2     = rs2;
    bus.branch_taken = br;
    bus.exmem_valid  = v;
    bus.exmem_mem_rd = mrd;
    bus.exmem_mem_wr = mwr;
    bus.dmem_ready   = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] got, input logic [31:0] e);
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, e);
    end
  endtask

  initial begin
    // Reset, including active inputs that must be ignored
    step("reset0",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, RST_V);
    step("reset1",      1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1, 0, 0, RST_V);
    step("idle",        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);

    // Load-use hazards
    step("lu_stall",    0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 0, LU);
    step("lu_release",  0, 0, 5'd0, 5'd5, 5'd6, 0, 0, 0, 0, 0, NORM);
    step("x0_no_haz",   0, 1, 5'd0, 5'd0, 5'd3, 0, 0, 0, 0, 0, NORM);
    step("lu_rs1",      0, 1, 5'd7, 5'd7, 5'd2, 0, 0, 0, 0, 0, LU);
    step("lu_other_rd", 0, 1, 5'd8, 5'd7, 5'd2, 0, 0, 0, 0, 0, NORM);

    // Store with three not-ready cycles
    step("st_wait0",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, STALL);
    step("st_wait1",    0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 0, STALL);
    step("st_wait2",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, STALL);
    step("st_ready",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, NORM_REQ);
    step("st_after",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);

    // Memory stall with a pending taken branch
    step("br_stall",    0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, STALL);
    step("br_wait",     0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, STALL);
    step("br_ready",    0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 1, BR_REQ);
    step("br_after",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);

    // Same-cycle completion keeps the load-use rule; branch beats load-use
    step("acc_rdy_lu",  0, 1, 5'd9, 5'd0, 5'd9, 0, 1, 1, 0, 1, LU_REQ);
    step("br_over_lu",  0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, 0, BR);
    step("invalid_acc", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, NORM);

`ifdef PIPE_STALL_CNT_EN
    check_cnt("stall_lu_cnt",  stall_lu_cnt,  32'd3);
    check_cnt("stall_mem_cnt", stall_mem_cnt, 32'd5);
`endif

    // Timeout: four wait cycles then ERR, which holds until reset
    step("to_run",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("to_w1",       0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("to_w2",       0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("to_w3",       0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("to_w4",       0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("to_err",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, ERRV);
    step("to_err_rdy",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, ERRV);
    step("to_rst",      1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, RST_V);
    step("to_clear",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);

`ifdef PIPE_STALL_CNT_EN
    check_cnt("cnt_rst_clear", stall_mem_cnt, 32'd0);
`endif

    // Reset in the middle of a wait drops the request at once
    step("rw_stall",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("rw_wait",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, STALL);
    step("rw_rst",      1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, RST_V);
    step("rw_release",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, NORM_REQ);
    step("rw_idle",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates the enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three stall sources: load-use hazards, taken branches, and a multi-cycle data memory handshake with timeout.
- Sits beside the datapath and consumes control bits already carried in the ID/EX and EX/MEM registers.

Parameters:
MEM_TIMEOUT, 16, max MEM_WAIT cycles before declaring a memory error; 0 disables the timeout
CNT_W, 32, width of the optional performance counters

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
idex_mem_rd  input  1  instruction in EX is a load
idex_rd  input  5  destination register of the instruction in EX
ifid_rs1  input  5  rs1 of the instruction in ID
ifid_rs2  input  5  rs2 of the instruction in ID
branch_taken  input  1  branch/jump resolved taken in EX this cycle
exmem_valid  input  1  EX/MEM holds a real, non-bubble instruction
exmem_mem_rd  input  1  instruction in MEM is a load
exmem_mem_wr  input  1  instruction in MEM is a store
dmem_ready  input  1  data memory completes the access this cycle
dmem_req  output  1  data memory request strobe
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID load enable
idex_en  output  1  ID/EX load enable
exmem_en  output  1  EX/MEM load enable
ifid_flush  output  1  IF/ID synchronous clear
idex_flush  output  1  ID/EX synchronous clear (bubble insert)
memwb_flush  output  1  MEM/WB synchronous clear
mem_timeout  output  1  sticky memory error flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Wait counter width: clog2(MEM_TIMEOUT+1).
- All outputs are combinational from state and inputs (zero latency). State, wait counter and mem_timeout are registered.
- Reset, while rst=1:
  - all enables = 0, all flushes = 1, dmem_req = 0, mem_timeout = 0.
  - Next state is RUN; wait counter is cleared to 0.
- Definitions:
  - mem_acc = exmem_valid & (exmem_mem_rd | exmem_mem_wr).
  - lu_haz = idex_mem_rd & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2).
- RUN:
  - dmem_req = mem_acc.
  - If mem_acc & !dmem_ready (memory stall, highest priority):
    - pc_en = ifid_en = idex_en = exmem_en = 0; memwb_flush = 1; branch_taken and lu_haz are ignored.
    - Next state MEM_WAIT, counter = 1.
  - Else if branch_taken:
    - all enables = 1; ifid_flush = idex_flush = 1; lu_haz is ignored because both younger instructions are squashed.
  - Else if lu_haz:
    - pc_en = ifid_en = 0; idex_en = exmem_en = 1; idex_flush = 1 (exactly one bubble per hazard).
  - Else:
    - all enables = 1, all flushes = 0.
  - mem_acc & dmem_ready in the same cycle: no stall; the branch and load-use rules above still apply.
- MEM_WAIT:
  - dmem_req = 1 held; all stages frozen as in a RUN memory stall; memwb_flush = 1; counter increments each cycle.
  - dmem_ready = 1: outputs in that cycle are identical to RUN with mem_acc & dmem_ready, evaluated with the current inputs (branch and load-use rules apply). Next state RUN, counter cleared.
  - MEM_TIMEOUT != 0, counter == MEM_TIMEOUT and !dmem_ready: next state ERR.
- ERR:
  - dmem_req = 0; all enables = 0; memwb_flush = 1; mem_timeout = 1.
  - Leaves only on rst.
- Reset asserted mid-MEM_WAIT: the request drops in the same cycle as rst; there is no pending handshake after release.
- The branch_taken rule assumes EX is not held. EX is held only during memory stalls, and the branch is re-presented afterwards.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Extra outputs stall_mem_cnt [CNT_W-1:0] and stall_lu_cnt [CNT_W-1:0].
  - stall_mem_cnt counts cycles with exmem_en = 0 while not in reset.
  - stall_lu_cnt counts cycles where the load-use bubble is inserted.
  - Both counters saturate at all-ones and clear on rst.
- Undefined:
  - Ports and counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Load x5 in EX, ifid_rs2 = 5, no memory access -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle all enables = 1.
- idex_rd = 0 with idex_mem_rd = 1, ifid_rs1 = 0 -> no stall.
- Store in MEM, dmem_ready low for 3 cycles then high -> dmem_req high 4 cycles, exmem_en = 0 for 3 cycles, memwb_flush = 1 for 3 cycles, RUN on the 4th.
- Memory stall plus branch_taken in the same cycle -> no flush while stalled; flush of IF/ID and ID/EX in the cycle dmem_ready = 1.
- MEM_TIMEOUT = 4, dmem_ready stuck low -> ERR entered after 4 wait cycles; mem_timeout = 1, dmem_req = 0; rst clears to RUN.
- With PIPE_STALL_CNT_EN, 2 load-use stalls plus a 3-cycle memory wait -> stall_lu_cnt = 2, stall_mem_cnt = 3.
